// File: rtl/train_sync_pkg.sv
// Shared types and the condition table for train_condition_sync.
// Each table entry selects a sensor mask and how that mask is evaluated.
package train_sync_pkg;

  localparam int TABLE_SENSORS = 6;
  localparam int TABLE_SEL_W   = 4;
  localparam int TABLE_SIZE    = 2 ** TABLE_SEL_W;

  typedef enum logic [1:0] {
    ANY   = 2'd0,
    NONE  = 2'd1,
    TIMER = 2'd2
  } cond_mode_t;

  typedef struct packed {
    cond_mode_t                 mode;
    logic [TABLE_SENSORS-1:0]   mask;
  } cond_entry_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ARMED      = 2'd1,
    FIRED      = 2'd2,
    WAIT_CLEAR = 2'd3
  } fsm_state_t;

  typedef cond_entry_t [TABLE_SIZE-1:0] cond_table_t;

  // Mask bit 0 is sensor S1, bit 5 is S6.
  function automatic cond_table_t buildCondTable();
    cond_table_t t;
    t     = '0;
    t[0]  = '{mode: ANY,   mask: 6'b100001};
    t[1]  = '{mode: ANY,   mask: 6'b010010};
    t[2]  = '{mode: TIMER, mask: 6'b000000};
    t[3]  = '{mode: TIMER, mask: 6'b000000};
    t[4]  = '{mode: TIMER, mask: 6'b000000};
    t[5]  = '{mode: TIMER, mask: 6'b000000};
    t[6]  = '{mode: ANY,   mask: 6'b000100};
    t[7]  = '{mode: ANY,   mask: 6'b001000};
    t[8]  = '{mode: ANY,   mask: 6'b001000};
    t[9]  = '{mode: ANY,   mask: 6'b000100};
    t[10] = '{mode: NONE,  mask: 6'b001111};
    t[11] = '{mode: NONE,  mask: 6'b111100};
    t[12] = '{mode: ANY,   mask: 6'b100000};
    t[13] = '{mode: ANY,   mask: 6'b000001};
    t[14] = '{mode: ANY,   mask: 6'b100000};
    t[15] = '{mode: ANY,   mask: 6'b000001};
    return t;
  endfunction

  localparam cond_table_t COND_TABLE = buildCondTable();

  function automatic logic evalCondition(
    input cond_entry_t              entry,
    input logic [TABLE_SENSORS-1:0] sens,
    input logic                     timerExp
  );
    case (entry.mode)
      ANY:     return |(sens & entry.mask);
      NONE:    return ~|(sens & entry.mask);
      TIMER:   return timerExp;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/train_condition_sync_debounce.sv
// Per-bit two-flop synchroniser, followed by a stability counter when the
// DEBOUNCE_EN macro is defined (otherwise the synchroniser output is used directly).
module sensor_debounce
`ifdef DEBOUNCE_EN
#(
  parameter int DEBOUNCE_CYCLES = 16
)
`endif
(
  input  logic CLK,
  input  logic RESET_N,
  input  logic rawIn,
  output logic cleanOut
);

  logic metaQ;
  logic syncQ;

  // NOTE: every flop here is a state element, so it uses <=; mixing in a
  // blocking assignment would let syncQ see this cycle's metaQ and collapse
  // the two stages into one.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      metaQ <= 1'b0;
      syncQ <= 1'b0;
    end else begin
      metaQ <= rawIn;
      syncQ <= metaQ;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] stableCnt;
  logic             cleanQ;

  // Count cycles where the synced value disagrees with the clean one; any
  // agreement (a glitch ending) restarts the count.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      stableCnt <= '0;
      cleanQ    <= 1'b0;
    end else if (syncQ == cleanQ) begin
      stableCnt <= '0;
    end else if (stableCnt == CNT_LAST) begin
      stableCnt <= '0;
      cleanQ    <= syncQ;
    end else begin
      stableCnt <= stableCnt + CNT_W'(1);
    end
  end

  assign cleanOut = cleanQ;
`else
  assign cleanOut = syncQ;
`endif

endmodule

// File: rtl/train_condition_sync.sv
// Condition synchroniser between track sensors and the train controller FSM.
// Optional sensor debouncing is built when the DEBOUNCE_EN macro is defined.
module train_condition_sync
  import train_sync_pkg::*;
#(
  parameter int NUM_SENSORS = TABLE_SENSORS,
  parameter int SEL_W       = TABLE_SEL_W,
  parameter int TIMER_W     = 16
`ifdef DEBOUNCE_EN
  ,
  parameter int DEBOUNCE_CYCLES = 16
`endif
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic [NUM_SENSORS-1:0] S,
  input  logic [SEL_W-1:0]       Selector,
  input  logic                   Enable,
  input  logic [TIMER_W-1:0]     TIMER_LOAD,
  input  logic                   ACK,
  output logic                   Y,
  output logic                   EVENT,
  output logic [NUM_SENSORS-1:0] SENS_CLEAN,
  output logic                   TIMER_EXP
);

  for (genvar i = 0; i < NUM_SENSORS; i++) begin : gSensor
`ifdef DEBOUNCE_EN
    sensor_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) uSensor (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .rawIn   (S[i]),
      .cleanOut(SENS_CLEAN[i])
    );
`else
    sensor_debounce uSensor (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .rawIn   (S[i]),
      .cleanOut(SENS_CLEAN[i])
    );
`endif
  end

  fsm_state_t       stateQ;
  fsm_state_t       stateD;
  logic             ackAccepted;
  logic             enterArmed;
  logic [SEL_W-1:0] selQ;
  logic             selChanged;
  logic             timerReload;
  logic [TIMER_W-1:0] timerCnt;
  logic [TIMER_W-1:0] timerCntNext;
  logic             timerExpQ;
  cond_entry_t      activeEntry;
  logic             condNow;
  logic             yQ;

  // NOTE: each always_comb output gets a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    stateD      = stateQ;
    ackAccepted = 1'b0;
    if (!Enable) begin
      stateD = IDLE;
    end else begin
      case (stateQ)
        IDLE:       stateD = ARMED;
        ARMED:      if (yQ) stateD = FIRED;
        FIRED: begin
          if (ACK) begin
            stateD      = WAIT_CLEAR;
            ackAccepted = 1'b1;
          end
        end
        WAIT_CLEAR: if (!yQ) stateD = ARMED;
        default:    stateD = IDLE;
      endcase
    end
  end

  assign enterArmed  = (stateD == ARMED) && (stateQ != ARMED);
  assign selChanged  = (Selector != selQ);
  assign timerReload = selChanged || enterArmed || ackAccepted;

  always_comb begin
    timerCntNext = timerCnt;
    if (timerReload) begin
      timerCntNext = TIMER_LOAD;
    end else if (timerCnt != '0) begin
      timerCntNext = timerCnt - TIMER_W'(1);
    end
  end

  // The expiry flag is registered from the next count so it matches
  // (timerCnt == 0) in every cycle while still reading 0 during reset.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      stateQ    <= IDLE;
      selQ      <= '0;
      timerCnt  <= '0;
      timerExpQ <= 1'b0;
      yQ        <= 1'b0;
    end else begin
      stateQ    <= stateD;
      selQ      <= Selector;
      timerCnt  <= timerCntNext;
      timerExpQ <= (timerCntNext == '0);
      yQ        <= condNow;
    end
  end

  assign activeEntry = COND_TABLE[Selector];
  assign condNow     = evalCondition(activeEntry, SENS_CLEAN, timerExpQ);

  assign Y         = yQ;
  assign EVENT     = (stateQ == FIRED);
  assign TIMER_EXP = timerExpQ;

endmodule
